// File: rtl/step_pulse_gen.sv
// -----------------------------------------------------------------------------
// step_pulse_gen
//
// Turns a raw, bouncy push-button into clean single-cycle step pulses for the
// downstream 3-bit T-flip-flop counter (step drives its toggle-enable), so one
// press advances that counter by exactly one count. Optional auto-repeat emits
// further steps while the button stays held.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset; clears all state immediately
//   btn_in     in   raw asynchronous button level, 1 = pressed
//   repeat_en  in   synchronous level, 1 = auto-repeat while held
//   step       out  registered one-cycle step pulse
//   btn_level  out  registered debounced button level
// -----------------------------------------------------------------------------
module step_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic step,
    output logic btn_level
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Terminal counts; each counter is cleared on reaching its terminal value,
    // so none can ever run past these and wrap.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync0_r;
    logic             sync1_r;
    logic             s_s;
    state_t           state_r;
    logic [CNT_W-1:0] dcnt_r;
    logic [CNT_W-1:0] rcnt_r;
    logic             phase_r;

    // Two-flop synchroniser bringing the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
        end else begin
            sync0_r <= btn_in;
            sync1_r <= sync0_r;
        end
    end

    assign s_s = sync1_r;

    // Debounce / auto-repeat state machine with registered step and btn_level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            dcnt_r    <= '0;
            rcnt_r    <= '0;
            phase_r   <= 1'b0;
            step      <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            // step is a pulse: low unless a branch below raises it this edge.
            step <= 1'b0;
            case (state_r)
                IDLE: begin
                    btn_level <= 1'b0;
                    if (s_s) begin
                        state_r <= DB_PRESS;
                        dcnt_r  <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                DB_PRESS: begin
                    if (!s_s) begin
                        // Bounce: input fell before it was stable long enough.
                        state_r <= IDLE;
                    end else if (dcnt_r == DB_LAST) begin
                        state_r   <= HELD;
                        step      <= 1'b1;
                        btn_level <= 1'b1;
                        rcnt_r    <= '0;
                        phase_r   <= 1'b0;
                    end else begin
                        dcnt_r <= dcnt_r + CNT_ONE;
                    end
                end

                HELD: begin
                    // A falling input takes priority over a due repeat pulse.
                    if (!s_s) begin
                        state_r <= DB_RELEASE;
                        dcnt_r  <= '0;
                    end else if (!repeat_en) begin
                        // Disabling repeat rearms the full initial delay.
                        rcnt_r  <= '0;
                        phase_r <= 1'b0;
                    end else if (!phase_r && (rcnt_r == RD_LAST)) begin
                        step    <= 1'b1;
                        rcnt_r  <= '0;
                        phase_r <= 1'b1;
                    end else if (phase_r && (rcnt_r == RR_LAST)) begin
                        step   <= 1'b1;
                        rcnt_r <= '0;
                    end else begin
                        rcnt_r <= rcnt_r + CNT_ONE;
                    end
                end

                DB_RELEASE: begin
                    if (s_s) begin
                        // Release glitch: still held, restart repeat timing.
                        state_r <= HELD;
                        rcnt_r  <= '0;
                        phase_r <= 1'b0;
                    end else if (dcnt_r == DB_LAST) begin
                        state_r   <= IDLE;
                        btn_level <= 1'b0;
                    end else begin
                        dcnt_r <= dcnt_r + CNT_ONE;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    dcnt_r    <= '0;
                    rcnt_r    <= '0;
                    phase_r   <= 1'b0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule
